// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD add/subtract controller.
package bcd_pkg;

    localparam int unsigned DIGIT_W = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ADD,
        ST_FIX,
        ST_DONE
    } state_t;

    function automatic logic [DIGIT_W-1:0] nines(input logic [DIGIT_W-1:0] d);
        return DIGIT_W'(4'd9 - d);
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit BCD adder: binary sum of two digits plus carry, +6 corrected above 9.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    output logic [DIGIT_W-1:0] s,
    output logic               cout
);

    logic [DIGIT_W:0] sum;

    always_comb begin
        sum  = (DIGIT_W+1)'(a) + (DIGIT_W+1)'(b) + (DIGIT_W+1)'(cin);
        cout = (sum > (DIGIT_W+1)'(9));
        s    = cout ? DIGIT_W'(sum + (DIGIT_W+1)'(6)) : sum[DIGIT_W-1:0];
    end

endmodule

// File: rtl/bcd_serial_addsub_ctrl.sv
// Digit-serial packed-BCD adder/subtractor: one shared digit cell, sign-magnitude result,
// tens-complement fix-up pass when a subtraction goes negative.
module bcd_serial_addsub_ctrl
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        op,
    input  logic [DIGIT_W*DIGITS-1:0]   a,
    input  logic [DIGIT_W*DIGITS-1:0]   b,
    output logic                        busy,
    output logic                        done,
    output logic [DIGIT_W*DIGITS-1:0]   result,
    output logic                        cout,
    output logic                        neg,
    output logic                        err
);

    localparam int unsigned W  = DIGIT_W * DIGITS;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t            state, state_n;
    logic [IW-1:0]     idx, idx_n;
    logic              carry, carry_n;
    logic [W-1:0]      a_q, a_n, b_q, b_n, result_n;
    logic              op_q, op_n;
    logic              cout_n, neg_n, err_n, busy_n, done_n;

    logic [DIGIT_W-1:0] a_dig, b_dig, r_dig;
    logic [DIGIT_W-1:0] cell_a, cell_b, cell_s;
    logic               cell_cout, bad_digit, last_digit;

    bcd_digit_add u_digit (
        .a    (cell_a),
        .b    (cell_b),
        .cin  (carry),
        .s    (cell_s),
        .cout (cell_cout)
    );

    // Select the current digit of each register and steer the shared cell
    always_comb begin
        a_dig     = '0;
        b_dig     = '0;
        r_dig     = '0;
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                a_dig = a_q[DIGIT_W*i +: DIGIT_W];
                b_dig = b_q[DIGIT_W*i +: DIGIT_W];
                r_dig = result[DIGIT_W*i +: DIGIT_W];
            end
            if (a_q[DIGIT_W*i +: DIGIT_W] > DIGIT_W'(9) || b_q[DIGIT_W*i +: DIGIT_W] > DIGIT_W'(9))
                bad_digit = 1'b1;
        end
        last_digit = (idx == IW'(DIGITS - 1));
        if (state == ST_FIX) begin
            cell_a = nines(r_dig);
            cell_b = '0;
        end else begin
            cell_a = a_dig;
            cell_b = (op_q == OP_SUB) ? nines(b_dig) : b_dig;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_n  = state;
        idx_n    = idx;
        carry_n  = carry;
        a_n      = a_q;
        b_n      = b_q;
        op_n     = op_q;
        result_n = result;
        cout_n   = cout;
        neg_n    = neg;
        err_n    = err;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    a_n      = a;
                    b_n      = b;
                    op_n     = op;
                    result_n = '0;
                    cout_n   = 1'b0;
                    neg_n    = 1'b0;
                    err_n    = 1'b0;
                    state_n  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (bad_digit) begin
                    err_n    = 1'b1;
                    result_n = '0;
                    state_n  = ST_DONE;
                end else begin
                    idx_n   = '0;
                    carry_n = (op_q == OP_SUB);
                    state_n = ST_ADD;
                end
            end
            ST_ADD, ST_FIX: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (idx == IW'(i))
                        result_n[DIGIT_W*i +: DIGIT_W] = cell_s;
                end
                carry_n = cell_cout;
                if (!last_digit) begin
                    idx_n = idx + IW'(1);
                end else begin
                    idx_n = '0;
                    if (state == ST_FIX) begin
                        state_n = ST_DONE;
                    end else if (op_q == OP_ADD) begin
                        cout_n  = cell_cout;
                        state_n = ST_DONE;
                    end else if (cell_cout) begin
                        neg_n   = 1'b0;
                        state_n = ST_DONE;
                    end else begin
                        // Borrow out: magnitude is the tens complement of what we have
                        neg_n   = 1'b1;
                        carry_n = 1'b1;
                        state_n = ST_FIX;
                    end
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        busy_n = (state_n != ST_IDLE);
        done_n = (state_n == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= OP_ADD;
            result <= '0;
            cout   <= 1'b0;
            neg    <= 1'b0;
            err    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            carry  <= carry_n;
            a_q    <= a_n;
            b_q    <= b_n;
            op_q   <= op_n;
            result <= result_n;
            cout   <= cout_n;
            neg    <= neg_n;
            err    <= err_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end

endmodule

// File: tb/tb_bcd_serial_addsub_ctrl.sv
// Self-checking bench: directed and random operations against an integer-arithmetic model.
module tb_bcd_serial_addsub_ctrl;

    localparam int unsigned D = 4;
    localparam int unsigned W = 4 * D;
    localparam int LIMIT = 100;

    logic         clk = 1'b0;
    logic         rst, start, op;
    logic [W-1:0] a, b, result;
    logic         busy, done, cout, neg, err;

    int n_tests = 0;
    int n_fail  = 0;

    bcd_serial_addsub_ctrl #(.DIGITS(D)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .neg    (neg),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint bcd2int(input logic [W-1:0] v);
        longint r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input longint v);
        logic [W-1:0] r = '0;
        longint x = v;
        for (int i = 0; i < int'(D); i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic bit has_bad(input logic [W-1:0] v);
        for (int i = 0; i < int'(D); i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    // Reference: decimal arithmetic on whole numbers, sign-magnitude for subtraction
    task automatic model(input logic o, input logic [W-1:0] ai, input logic [W-1:0] bi,
                         output logic [W-1:0] r, output logic c, output logic n,
                         output logic e, output int lat);
        longint av, bv, modv;
        modv = 1;
        for (int i = 0; i < int'(D); i++) modv = modv * 10;
        r = '0; c = 1'b0; n = 1'b0; e = 1'b0;
        if (has_bad(ai) || has_bad(bi)) begin
            e = 1'b1; lat = 2;
            return;
        end
        av = bcd2int(ai);
        bv = bcd2int(bi);
        lat = int'(D) + 2;
        if (o == 1'b0) begin
            r = int2bcd((av + bv) % modv);
            c = (av + bv) >= modv;
        end else if (av >= bv) begin
            r = int2bcd(av - bv);
        end else begin
            r = int2bcd(bv - av);
            n = 1'b1;
            lat = 2 * int'(D) + 2;
        end
    endtask

    task automatic run_op(input logic o, input logic [W-1:0] ai, input logic [W-1:0] bi,
                          input bit noise);
        logic [W-1:0] er;
        logic ec, en, ee;
        int lat, cyc;
        model(o, ai, bi, er, ec, en, ee, lat);
        @(negedge clk);
        op = o; a = ai; b = bi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < LIMIT) begin
            chk("busy_during_op", 64'(busy), 64'(1));
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                a = W'($urandom);
                b = W'($urandom);
                op = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("done_seen", 64'(done), 64'(1));
        chk("latency", 64'(cyc), 64'(lat));
        chk("result", 64'(result), 64'(er));
        chk("cout", 64'(cout), 64'(ec));
        chk("neg", 64'(neg), 64'(en));
        chk("err", 64'(err), 64'(ee));
        @(negedge clk);
        chk("done_pulse_len", 64'(done), 64'(0));
        chk("busy_after", 64'(busy), 64'(0));
        chk("result_held", 64'(result), 64'(er));
        chk("flags_held", 64'({cout, neg, err}), 64'({ec, en, ee}));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         ro;
        int           cyc;

        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        chk("reset_outputs", 64'({busy, done, cout, neg, err, result}), 64'(0));
        rst = 1'b0; start = 1'b0;

        run_op(1'b0, 16'h1234, 16'h5678, 1'b0);
        run_op(1'b0, 16'h9999, 16'h0001, 1'b0);
        run_op(1'b1, 16'h5000, 16'h1234, 1'b0);
        run_op(1'b1, 16'h1234, 16'h5000, 1'b0);
        run_op(1'b1, 16'h0042, 16'h0042, 1'b0);
        run_op(1'b0, 16'h00A0, 16'h0001, 1'b1);
        run_op(1'b1, 16'h1234, 16'h5000, 1'b1);

        // Reset in cycle 3 of a subtraction
        @(negedge clk);
        op = 1'b1; a = 16'h1234; b = 16'h5000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_reset_outputs", 64'({busy, done, cout, neg, err, result}), 64'(0));
        rst = 1'b0;
        run_op(1'b0, 16'h0505, 16'h0505, 1'b0);

        // Start held through DONE is only taken once back in IDLE
        @(negedge clk);
        op = 1'b0; a = 16'h0019; b = 16'h0001; start = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (!done && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        chk("hold_done_seen", 64'(done), 64'(1));
        chk("hold_latency", 64'(cyc), 64'(D + 2));
        @(negedge clk);
        chk("hold_idle_gap", 64'({busy, done}), 64'(0));
        @(negedge clk);
        start = 1'b0;
        chk("hold_restart_busy", 64'(busy), 64'(1));
        cyc = 2;
        while (!done && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        chk("hold_second_done", 64'(done), 64'(1));
        chk("hold_second_result", 64'(result), 64'(16'h0020));
        @(negedge clk);

        for (int t = 0; t < 40; t++) begin
            ra = '0; rb = '0;
            for (int i = 0; i < int'(D); i++) begin
                ra[4*i +: 4] = 4'($urandom_range(0, 9));
                rb[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 7) == 0) ra[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
            if ($urandom_range(0, 7) == 0) rb[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
            ro = 1'($urandom_range(0, 1));
            run_op(ro, ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_serial_addsub_ctrl.md
BCD_SERIAL_ADDSUB_CTRL -- requirements
Module: bcd_serial_addsub_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 4, giving the number of packed BCD digits per operand (legal range 1..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 SHALL have port op, input, 1 bit: 0 = A+B, 1 = A-B.
REQ-006 SHALL have port a, input, 4*DIGITS bits: packed BCD operand A; digit 0 is in bits [3:0].
REQ-007 SHALL have port b, input, 4*DIGITS bits: packed BCD operand B, same packing as a.
REQ-008 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port result, output, 4*DIGITS bits: packed BCD magnitude of the result.
REQ-011 SHALL have port cout, output, 1 bit: decimal carry out of the most significant digit (add only).
REQ-012 SHALL have port neg, output, 1 bit: subtraction result is negative; result holds the magnitude.
REQ-013 SHALL have port err, output, 1 bit: some operand digit is greater than 9.

Function
REQ-014 SHALL implement the states IDLE, CHECK, ADD, FIX and DONE.
REQ-015 SHALL, in IDLE with start=1, latch a, b and op, clear result, cout, neg and err, and go to CHECK.
REQ-016 SHALL, in CHECK, go to DONE with err=1 and result=0 if any latched digit is above 9; otherwise go to ADD with digit index 0.
REQ-017 SHALL set the initial carry to 0 for add; for sub, it SHALL set the initial carry to 1 and replace each B digit with its nines complement (9-d).
REQ-018 SHALL, in ADD, process one digit per cycle: binary sum of A digit, B' digit and carry; if the sum is above 9, add 6 and set carry out; write the corrected digit into result[4i+3:4i].
REQ-019 SHALL leave ADD after digit DIGITS-1 as follows:
- add: cout = final carry, go to DONE.
- sub with final carry 1: neg=0, go to DONE.
- sub with final carry 0: neg=1, go to FIX with digit index 0.
REQ-020 SHALL, in FIX, replace result with its tens complement, one digit per cycle (nines complement of the digit plus carry, initial carry 1, same +6 correction), then go to DONE.
REQ-021 SHALL, in DONE, assert done for exactly one cycle and return to IDLE.
REQ-022 SHALL hold result, cout, neg and err stable from DONE until the next accepted start.
REQ-023 SHALL give these latencies, counting the start-sampled cycle as cycle 0; done is high in:
- cycle DIGITS+2 for add and for non-negative sub.
- cycle 2*DIGITS+2 for negative sub.
- cycle 2 for an err result.
REQ-024 SHALL ignore start while busy=1; start held high in DONE is not accepted until IDLE.
REQ-025 SHALL wrap a 9..9 + 0..1 add to result 0 with cout=1; no result width growth.

Reset
REQ-026 SHALL, on rst=1 at a rising edge (including mid-operation), enter IDLE and clear busy, done, result, cout, neg, err, the digit index and the carry register.
REQ-027 SHALL give rst priority over start in the same cycle.

Structure
REQ-028 SHALL take the state encoding and the OP_ADD/OP_SUB constants from a shared package bcd_pkg.
REQ-029 SHALL instantiate a single combinational one-digit cell bcd_digit_add, with inputs a, b and cin, outputs s and cout, shared by ADD and FIX.
REQ-030 SHALL keep only a digit index, a carry register and the result and operand registers as datapath state; no per-digit adder replication.

Verification
REQ-031 SHALL cover: DIGITS=4, op=0, a=1234, b=5678 -> result 6912, cout 0, neg 0, done in cycle 6.
REQ-032 SHALL cover: op=0, a=9999, b=0001 -> result 0000, cout 1, done in cycle 6.
REQ-033 SHALL cover: op=1, a=5000, b=1234 -> result 3766, neg 0, done in cycle 6.
REQ-034 SHALL cover: op=1, a=1234, b=5000 -> result 3766, neg 1, done in cycle 10; also a=b=0042 -> result 0000, neg 0.
REQ-035 SHALL cover: a=00A0 -> err 1, result 0000, done in cycle 2; start pulses during busy -> no effect.
REQ-036 SHALL cover: rst in cycle 3 of a subtraction -> next cycle busy 0 and all outputs 0; a following start completes normally.
